// File: rtl/gpr_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
//   XLEN_DEFAULT / NREG_DEFAULT : default data width and register count
//   REG_ZERO / REG_A7           : hardwired-zero register and ecall index register
//   clog2()                     : elaboration-time address width helper
//   popcount()                  : set-bit count of a busy vector, up to POPCNT_W bits
package gpr_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned REG_A7       = 17;

  // Widest busy vector popcount() can take; callers zero-extend into it.
  localparam int unsigned POPCNT_W = 256;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned popcount(input logic [POPCNT_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < POPCNT_W; i++) begin
      c += {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Write-pending scoreboard: one busy bit per register.
//   clock, reset         : clock and synchronous active-high reset
//   rd_addr / rd_busy    : per-read-port busy lookup (optionally bypassed)
//   wr_en / wr_addr      : writeback ports, clear busy
//   iss_en / iss_addr    : issue port, sets busy (wins over a same-cycle clear)
//   busy_cnt             : registered count of busy registers
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int unsigned NREG   = NREG_DEFAULT,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [AW:0]       busy_cnt
);

  logic [NREG-1:0] busy_q, busy_d, wr_hit;
  logic [AW:0]     cnt_q;

  always_comb begin
    wr_hit = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (wr_en[p]) wr_hit[wr_addr[p*AW +: AW]] = 1'b1;
    end
    // Set after clear: a new producer supersedes the one writing back.
    busy_d = busy_q & ~wr_hit;
    if (iss_en) busy_d[iss_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      // busy_d[0] is always 0, so this is the count over registers 1..NREG-1.
      cnt_q  <= (AW+1)'(popcount(POPCNT_W'(busy_d)));
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    a       = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a          = rd_addr[k*AW +: AW];
      rd_busy[k] = busy_q[a];
      if (BYPASS != 0 && wr_hit[a] && !(iss_en && iss_addr == a)) rd_busy[k] = 1'b0;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file with integrated busy scoreboard.
//   clock, reset                : clock and synchronous active-high reset
//   rd_addr / rd_data / rd_busy : NRD combinational read ports (optional write bypass)
//   wr_en / wr_addr / wr_data   : NWR write ports, highest index wins on collision
//   iss_en / iss_addr           : marks a register as having an in-flight producer
//   dbg_addr / dbg_data         : unbypassed debug read
//   busy_cnt                    : number of busy registers
//   a7_data                     : stored value of register 17 (0 if it does not exist)
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREG   = NREG_DEFAULT,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic [AW:0]         busy_cnt,
  output logic [XLEN-1:0]     a7_data
);

  logic [XLEN-1:0] regs_q [NREG];

  // Register 0 is only ever cleared, so it reads back as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      // Later ports override earlier ones on an address collision.
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] != '0) begin
          regs_q[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    a       = '0;
    rd_data = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      rd_data[k*XLEN +: XLEN] = regs_q[a];
      if (BYPASS != 0 && a != '0) begin
        for (int unsigned p = 0; p < NWR; p++) begin
          if (wr_en[p] && wr_addr[p*AW +: AW] == a) rd_data[k*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  assign dbg_data = regs_q[dbg_addr];

  if (NREG > REG_A7) begin : g_a7
    assign a7_data = regs_q[REG_A7];
  end else begin : g_no_a7
    assign a7_data = '0;
  end

  gpr_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: instance A (NWR=2, BYPASS=1) and instance B (NWR=1, BYPASS=0)
// share stimulus (B sees write port 0 only) and are checked every cycle against a
// register/busy array model, plus directed literal expectations.
module tb_gpr_file_mp;

  logic         clock = 1'b0;
  logic         reset;
  logic [9:0]   rd_addr;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         iss_en;
  logic [4:0]   iss_addr;
  logic [4:0]   dbg_addr;

  logic [127:0] rd_data_a, rd_data_b;
  logic [1:0]   rd_busy_a, rd_busy_b;
  logic [63:0]  dbg_a, dbg_b, a7_a, a7_b;
  logic [5:0]   cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  initial forever #5 clock = ~clock;

  gpr_file_mp #(
    .XLEN (64), .NREG (32), .NRD (2), .NWR (2), .BYPASS (1)
  ) dut_a (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_a),
    .rd_busy  (rd_busy_a),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_a),
    .busy_cnt (cnt_a),
    .a7_data  (a7_a)
  );

  gpr_file_mp #(
    .XLEN (64), .NREG (32), .NRD (2), .NWR (1), .BYPASS (0)
  ) dut_b (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_b),
    .rd_busy  (rd_busy_b),
    .wr_en    (wr_en[0:0]),
    .wr_addr  (wr_addr[4:0]),
    .wr_data  (wr_data[63:0]),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_b),
    .busy_cnt (cnt_b),
    .a7_data  (a7_b)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_regs [2][32];
  bit          m_busy [2][32];
  bit          model_ok = 1'b0;

  function automatic int nwr(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic bit wr_to(input int i, input logic [4:0] a);
    bit hit = 1'b0;
    for (int p = 0; p < nwr(i); p++) if (wr_en[p] && wr_addr[p*5 +: 5] == a) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [63:0] exp_rd(input int i, input int k);
    logic [4:0]  a = rd_addr[k*5 +: 5];
    logic [63:0] v;
    if (a == 5'd0) return 64'd0;
    v = m_regs[i][a];
    if (i == 0) begin
      for (int p = 0; p < 2; p++) if (wr_en[p] && wr_addr[p*5 +: 5] == a) v = wr_data[p*64 +: 64];
    end
    return v;
  endfunction

  function automatic logic exp_busy(input int i, input int k);
    logic [4:0] a = rd_addr[k*5 +: 5];
    if (a == 5'd0) return 1'b0;
    if (i == 0 && wr_to(0, a) && !(iss_en && iss_addr == a)) return 1'b0;
    return m_busy[i][a];
  endfunction

  function automatic logic [63:0] exp_cnt(input int i);
    int c = 0;
    for (int r = 1; r < 32; r++) c += int'(m_busy[i][r]);
    return 64'(c);
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) begin
          m_regs[i][r] = 64'd0;
          m_busy[i][r] = 1'b0;
        end
      end else begin
        for (int p = 0; p < nwr(i); p++) begin
          if (wr_en[p] && wr_addr[p*5 +: 5] != 5'd0) begin
            m_regs[i][wr_addr[p*5 +: 5]] = wr_data[p*64 +: 64];
            m_busy[i][wr_addr[p*5 +: 5]] = 1'b0;
          end
        end
        if (iss_en && iss_addr != 5'd0) m_busy[i][iss_addr] = 1'b1;
      end
    end
    if (reset) model_ok = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("a.rd_data%0d", k), rd_data_a[k*64 +: 64], exp_rd(0, k));
        chk($sformatf("b.rd_data%0d", k), rd_data_b[k*64 +: 64], exp_rd(1, k));
        chk($sformatf("a.rd_busy%0d", k), 64'(rd_busy_a[k]), 64'(exp_busy(0, k)));
        chk($sformatf("b.rd_busy%0d", k), 64'(rd_busy_b[k]), 64'(exp_busy(1, k)));
      end
      chk("a.dbg_data", dbg_a, m_regs[0][dbg_addr]);
      chk("b.dbg_data", dbg_b, m_regs[1][dbg_addr]);
      chk("a.busy_cnt", 64'(cnt_a), exp_cnt(0));
      chk("b.busy_cnt", 64'(cnt_b), exp_cnt(1));
      chk("a.a7_data", a7_a, m_regs[0][17]);
      chk("b.a7_data", a7_b, m_regs[1][17]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    iss_en = 1'b0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 5));
  endfunction

  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; dbg_addr = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset clears a written register.
    wr_en = 2'b01; wr_addr = 10'd5; wr_data = 128'hDEAD;
    cyc(); idle(); dbg_addr = 5'd5;
    @(negedge clock); chk("lit.r5_written", dbg_a, 64'hDEAD);
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    @(negedge clock);
    chk("lit.r5_after_reset", dbg_a, 64'd0);
    chk("lit.cnt_after_reset", 64'(cnt_a), 64'd0);

    // Writes to r0 are dropped, even on the bypass path.
    cyc(); wr_en = 2'b01; wr_addr = 10'd0; wr_data = 128'h1234; rd_addr = 10'd0;
    @(negedge clock); chk("lit.r0_same_cycle", rd_data_a[63:0], 64'd0);
    cyc(); idle();
    @(negedge clock); chk("lit.r0_later", rd_data_a[63:0], 64'd0);

    // Dual-port collision on r3: port 1 wins, debug port stays unbypassed.
    cyc(); wr_en = 2'b01; wr_addr = 10'd3; wr_data = 128'h77;
    cyc(); wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {64'hBBBB, 64'hAAAA};
    rd_addr = {5'd0, 5'd3}; dbg_addr = 5'd3;
    @(negedge clock);
    chk("lit.bypass_port1_wins", rd_data_a[63:0], 64'hBBBB);
    chk("lit.dbg_old_value", dbg_a, 64'h77);
    cyc(); idle();
    @(negedge clock);
    chk("lit.r3_stored", dbg_a, 64'hBBBB);

    // No bypass: r7 appears one cycle after the write.
    cyc(); wr_en = 2'b01; wr_addr = 10'd7; wr_data = 128'h55; rd_addr = 10'd7;
    @(negedge clock); chk("lit.nobyp_old", rd_data_b[63:0], 64'd0);
    cyc(); idle();
    @(negedge clock); chk("lit.nobyp_new", rd_data_b[63:0], 64'h55);

    // Scoreboard set / set-wins / clear.
    cyc(); iss_en = 1'b1; iss_addr = 5'd10;
    cyc(); idle(); rd_addr = 10'd10;
    @(negedge clock);
    chk("lit.busy_r10", 64'(rd_busy_a[0]), 64'd1);
    chk("lit.cnt_one", 64'(cnt_a), 64'd1);
    cyc(); wr_en = 2'b01; wr_addr = 10'd10; wr_data = 128'h1; iss_en = 1'b1; iss_addr = 5'd10;
    @(negedge clock); chk("lit.set_wins_busy", 64'(rd_busy_a[0]), 64'd1);
    cyc(); idle();
    @(negedge clock); chk("lit.set_wins_cnt", 64'(cnt_a), 64'd1);
    cyc(); wr_en = 2'b01; wr_addr = 10'd10; wr_data = 128'h2;
    @(negedge clock);
    chk("lit.clear_bypassed", 64'(rd_busy_a[0]), 64'd0);
    chk("lit.clear_nobyp", 64'(rd_busy_b[0]), 64'd1);
    cyc(); idle();
    @(negedge clock); chk("lit.cnt_zero", 64'(cnt_a), 64'd0);

    // Sweep: all of r1..r31 busy, then reset mid-sweep.
    for (int r = 1; r < 32; r++) begin
      cyc(); iss_en = 1'b1; iss_addr = 5'(r);
    end
    cyc(); idle();
    @(negedge clock);
    chk("lit.cnt_31_a", 64'(cnt_a), 64'd31);
    chk("lit.cnt_31_b", 64'(cnt_b), 64'd31);
    for (int r = 1; r < 8; r++) begin
      cyc(); iss_en = 1'b1; iss_addr = 5'(r);
    end
    cyc(); idle(); reset = 1'b1;
    cyc(); reset = 1'b0;
    @(negedge clock); chk("lit.cnt_reset_mid", 64'(cnt_a), 64'd0);
    cyc(); wr_en = 2'b01; wr_addr = 10'd17; wr_data = 128'h11;
    cyc(); idle();
    @(negedge clock);
    chk("lit.a7_a", a7_a, 64'h11);
    chk("lit.a7_b", a7_b, 64'h11);

    // Randomized traffic with heavy address reuse to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset    = ($urandom_range(0, 99) == 0);
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {rand_addr(), rand_addr()};
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      iss_en   = ($urandom_range(0, 2) != 0);
      iss_addr = rand_addr();
      rd_addr  = {rand_addr(), rand_addr()};
      dbg_addr = rand_addr();
    end
    cyc(); reset = 1'b0; idle();
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_file_mp.md
# gpr_file_mp

Parametrised multi-port general-purpose register file with an integrated write-pending scoreboard, used by the pipelined core in place of the single-read-pair, single-write register file. It provides NRD asynchronous read ports and NWR synchronous write ports, with optional same-cycle write-to-read bypass. Per-register busy bits track in-flight producers so that decode can stall on RAW hazards. The block sits between decode (reads and issue marking) and writeback (writes and busy clearing).

## Interface
- XLEN, 64: data width per register.
- NREG, 32: number of registers, power of two, ≥ 2; AW = clog2(NREG).
- NRD, 2: number of read ports, 1..4.
- NWR, 1: number of write ports, 1..2.
- BYPASS, 1: 1 = a same-cycle write is visible on the read ports and clears busy in the same cycle.

- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port.
- rd_busy  out  NRD  busy bit of each addressed register.
- wr_en  in  NWR  write enable per write port.
- wr_addr  in  NWR*AW  write address per port.
- wr_data  in  NWR*XLEN  write data per port.
- iss_en  in  1  marks iss_addr as having an in-flight producer.
- iss_addr  in  AW  destination register of the issuing instruction.
- dbg_addr  in  AW  debug/difftest read address.
- dbg_data  out  XLEN  unbypassed contents of regs[dbg_addr].
- busy_cnt  out  AW+1  number of busy registers.
- a7_data  out  XLEN  regs[17], the ecall index; 0 when NREG ≤ 17.

## Operation
- Register 0 is hardwired to 0: writes to it are dropped, iss_en to it is ignored, its busy bit is always 0, and reads return 0 even when bypassed.
- Reads are combinational: rd_data[k] = regs[rd_addr[k]].
  - If BYPASS=1 and some enabled write port targets rd_addr[k] (≠0) this cycle, rd_data[k] returns that port's wr_data.
  - If several write ports target the same address, the highest-index port wins, for both the bypassed read and the stored value.
- Writes: on the clock edge, each enabled port with a non-zero address updates regs[wr_addr].
- Scoreboard: busy[r] is set by iss_en with iss_addr=r and cleared by any enabled write to r.
  - If set and clear target the same register in one cycle, set wins: busy stays 1, because a new producer supersedes the old one.
- rd_busy[k] = busy[rd_addr[k]].
  - If BYPASS=1 and a write to that register occurs this cycle without a simultaneous iss_en to it, rd_busy[k] = 0.
- busy_cnt equals the population count of busy[NREG-1:1]. It is registered and updated in the same edge as busy.
- dbg_data and a7_data read stored state only; they never use the bypass path.

## Timing
- Reset: all regs = 0, all busy = 0, busy_cnt = 0.
  - With reset asserted, every output reads 0 one cycle later.
  - Writes and iss_en in a reset cycle are discarded.
  - Reset asserted mid-operation drops all pending busy bits.
- Write-to-read latency: 0 cycles with BYPASS=1; otherwise 1 cycle, so the new value is visible the cycle after the edge.
- Issue-to-busy latency: 1 cycle; rd_busy asserts in the cycle after iss_en.
- Writeback-to-not-busy latency: 0 cycles with BYPASS=1; otherwise 1 cycle.
- No handshake: every enabled write is accepted unconditionally. The block has no back-pressure.
- Writes to a non-busy register are legal, store normally, and leave busy at 0.

## Structure
- Shared package gpr_pkg holds:
  - XLEN_DEFAULT = 64, NREG_DEFAULT = 32;
  - REG_ZERO = 0, REG_A7 = 17;
  - a clog2 helper function;
  - a popcount function used for busy_cnt.
- One sub-module, gpr_scoreboard, holds the busy vector, the set/clear priority logic, busy_cnt, and the rd_busy lookup. The data array and bypass mux remain in gpr_file_mp.

## Test plan
- Reset check: write 0xDEAD to r5, assert reset for 1 cycle → r5 = 0, busy = 0, busy_cnt = 0.
- Write to r0: wr_en=1, wr_addr=0, wr_data=0x1234 → rd_data of r0 = 0 in the same cycle and every later cycle.
- Bypass, NWR=2, BYPASS=1: port0 writes r3 = 0xAAAA and port1 writes r3 = 0xBBBB in the same cycle while rd_addr0 = 3 → rd_data0 = 0xBBBB that cycle, stored r3 = 0xBBBB afterwards, dbg_data = old value until the edge.
- BYPASS=0: write r7 = 0x55 → rd_data still shows the old r7 that cycle and shows 0x55 the next cycle.
- Scoreboard: iss_en on r10 → rd_busy = 1 and busy_cnt = 1 next cycle. Write r10 together with iss_en on r10 in the same cycle → busy stays 1 and busy_cnt stays 1. A later write to r10 without issue → rd_busy = 0 (BYPASS=1, same cycle) and busy_cnt = 0 next cycle.
- Sweep: issue all of r1..r31 → busy_cnt = 31. Then reset mid-sweep → busy_cnt = 0 the next cycle. Finally, write 0x11 to r17 → a7_data = 0x11 the following cycle.
